iter_divider: RTL

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider_pkg.sv | 16 +
 rtl/iter_divider_div_step.sv | 34 +++
 rtl/iter_divider.sv | 135 +++++++++++++
 3 files changed

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// operand width and the number of radix-2 steps per division.
package iter_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage : iter_divider_pkg

// File: rtl/iter_divider_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one and
// trial-subtract the divisor from the (W+1)-bit shifted partial remainder.
module div_step
    import iter_divider_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0]   w_shift;
    logic [W-1:0] w_sub;
    logic         w_ge;

    assign w_shift = {i_rem, i_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    // When the trial subtraction succeeds the true difference is below 2^W,
    // so a W-bit modular subtract is exact.
    assign w_sub   = w_shift[W-1:0] - i_divisor;

    always_comb begin
        o_rem = w_shift[W-1:0];
        o_quo = {i_quo[W-2:0], 1'b0};
        if (w_ge) begin
            o_rem = w_sub;
            o_quo = {i_quo[W-2:0], 1'b1};
        end
    end

endmodule : div_step

// File: rtl/iter_divider.sv
// Iterative 32-step restoring divider on unsigned magnitudes with a final
// optional two's-complement correction of quotient and remainder.
module iter_divider #(
    parameter int DIV_WIDTH = iter_divider_pkg::DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_begin,
    input  logic                 div_sign,
    input  logic                 div_dividend_sign,
    input  logic [DIV_WIDTH-1:0] div_dividend,
    input  logic [DIV_WIDTH-1:0] div_divisor,
    output logic [DIV_WIDTH-1:0] div_quotient,
    output logic [DIV_WIDTH-1:0] div_remainder,
    output logic                 div_done,
    output logic                 div_busy
);
    import iter_divider_pkg::*;

    div_state_e           r_state;
    div_state_e           w_state_next;
    logic [CNT_W-1:0]     r_count;
    logic [DIV_WIDTH-1:0] r_rem;
    logic [DIV_WIDTH-1:0] r_quo;
    logic [DIV_WIDTH-1:0] r_divisor;
    logic                 r_neg_quo;
    logic                 r_neg_rem;
    logic [DIV_WIDTH-1:0] r_quotient;
    logic [DIV_WIDTH-1:0] r_remainder;
    logic [DIV_WIDTH-1:0] w_step_rem;
    logic [DIV_WIDTH-1:0] w_step_quo;
    logic                 w_last_step;

    div_step #(
        .W (DIV_WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign w_last_step = (r_count == CNT_W'(DIV_STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dropping div_begin while busy aborts without touching the outputs.
    always_comb begin
        w_state_next = r_state;
        div_done     = 1'b0;
        div_busy     = 1'b0;
        case (r_state)
            IDLE: begin
                if (div_begin) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                div_busy = 1'b1;
                if (!div_begin) begin
                    w_state_next = IDLE;
                end else if (w_last_step) begin
                    w_state_next = SIGN;
                end
            end
            SIGN: begin
                div_busy = 1'b1;
                if (!div_begin) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                div_done     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_neg_quo   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_begin) begin
                        r_count   <= '0;
                        r_rem     <= '0;
                        r_quo     <= div_dividend;
                        r_divisor <= div_divisor;
                        r_neg_quo <= div_sign;
                        r_neg_rem <= div_dividend_sign;
                    end
                end
                CALC: begin
                    if (div_begin) begin
                        r_rem   <= w_step_rem;
                        r_quo   <= w_step_quo;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                SIGN: begin
                    if (div_begin) begin
                        r_quotient  <= r_neg_quo ? ({DIV_WIDTH{1'b0}} - r_quo) : r_quo;
                        r_remainder <= r_neg_rem ? ({DIV_WIDTH{1'b0}} - r_rem) : r_rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_quotient  = r_quotient;
    assign div_remainder = r_remainder;

endmodule : iter_divider
